// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
//   parity_mode_e : encoding of the PARITY_MODE parameter (none / even / odd)
//   tx_state_e    : transmit FSM states
//   calc_parity   : parity bit for a data word under a given mode
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Widest legal data word; narrower words are zero-extended, which leaves XOR parity unchanged.
    localparam int MAX_DATA_W = 9;

    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                         input parity_mode_e          mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO, no fall-through: a word pushed at edge k can be popped at edge k+1
// at the earliest. full/empty/level are registered, derived from next-state pointers that carry
// one extra wrap bit.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write request, ignored while full (even if a pop happens on the same edge)
//   pop      : read request, ignored while empty
//   wdata    : word written on an accepted push
//   rdata    : word at the head (valid while !empty)
//   full, empty, level : registered status
module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [AW:0]  level_r;
    logic         full_r;
    logic         empty_r;
    logic         push_ok_s;
    logic         pop_ok_s;
    logic [AW:0]  wr_nxt_s;
    logic [AW:0]  rd_nxt_s;

    // Qualify requests with the registered flags and form next-state pointers.
    always_comb begin
        push_ok_s = push & ~full_r;
        pop_ok_s  = pop & ~empty_r;
        if (push_ok_s) begin
            wr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
    end

    // Pointer and status registers; full = same index with differing wrap bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            level_r  <= wr_nxt_s - rd_nxt_s;
            full_r   <= (wr_nxt_s[AW] != rd_nxt_s[AW]) && (wr_nxt_s[AW-1:0] == rd_nxt_s[AW-1:0]);
            empty_r  <= (wr_nxt_s == rd_nxt_s);
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/uart_tx_param_check.sv
// Elaboration-time legality checks for the transmitter parameters.
// No ports: instantiate inside uart_tx_fifo_param with the same parameter values.
module uart_tx_param_check #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) ();

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_fifo_param: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo_param: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_fifo_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input FIFO. Words are queued, then sent as
// start bit, DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits, each bit
// lasting CLKS_PER_BIT cycles. Queued words follow each other with no idle gap.
//   t_clk, t_rst       : clock, synchronous active-high reset (aborts any frame in flight)
//   UART_Tx_RQST       : write request, accepted when UART_Tx_READY_BUSY=1
//   Tx_DATA            : word to send, sampled on the accepting edge
//   UART_Tx_READY_BUSY : 1 = FIFO can accept a word
//   UART_Tx_OUT        : registered serial line, idle high
//   tx_idle            : FSM idle and FIFO empty
//   fifo_level         : FIFO occupancy
//   overflow_err       : sticky, set by a request while full; err_clr clears (set wins)
//   err_clr            : clears overflow_err
module uart_tx_fifo_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          t_clk,
    input  logic                          t_rst,
    input  logic                          UART_Tx_RQST,
    input  logic [DATA_W-1:0]             Tx_DATA,
    output logic                          UART_Tx_READY_BUSY,
    output logic                          UART_Tx_OUT,
    output logic                          tx_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_err,
    input  logic                          err_clr
);

    import uart_pkg::*;

    localparam int                  CW        = $clog2(CLKS_PER_BIT);
    localparam parity_mode_e        PAR_CFG   = parity_mode_e'(2'(PARITY_MODE));
    localparam logic [CW-1:0]       LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]          LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0]          LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_e           state_r;
    logic [CW-1:0]       clk_cnt_r;
    logic [3:0]          bit_idx_r;
    logic [DATA_W-1:0]   shift_r;
    logic                parity_r;
    logic                tx_line_r;
    logic                tx_idle_r;
    logic                overflow_r;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [DATA_W-1:0]   fifo_rdata_s;
    logic                pop_s;
    logic                last_tick_s;

    uart_tx_param_check #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PARITY_MODE (PARITY_MODE),
        .STOP_BITS   (STOP_BITS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_param_check ();

    uart_sync_fifo #(
        .W    (DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (t_clk),
        .rst  (t_rst),
        .push (UART_Tx_RQST),
        .pop  (pop_s),
        .wdata(Tx_DATA),
        .rdata(fifo_rdata_s),
        .full (fifo_full_s),
        .empty(fifo_empty_s),
        .level(fifo_level)
    );

    // Pop when idle, or on the final cycle of the final stop bit so the next start follows directly.
    always_comb begin
        last_tick_s = (clk_cnt_r == LAST_TICK);
        if (state_r == IDLE) begin
            pop_s = ~fifo_empty_s;
        end else if ((state_r == STOP) && last_tick_s && (bit_idx_r == LAST_STOP)) begin
            pop_s = ~fifo_empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Transmit FSM with bit-period counter, bit index, shift register and line register.
    always_ff @(posedge t_clk) begin
        if (t_rst) begin
            state_r   <= IDLE;
            clk_cnt_r <= '0;
            bit_idx_r <= 4'd0;
            shift_r   <= '0;
            parity_r  <= 1'b0;
            tx_line_r <= 1'b1;
            tx_idle_r <= 1'b1;
        end else begin
            tx_idle_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= '0;
                    bit_idx_r <= 4'd0;
                    if (pop_s) begin
                        shift_r   <= fifo_rdata_s;
                        parity_r  <= calc_parity(MAX_DATA_W'(fifo_rdata_s), PAR_CFG);
                        tx_line_r <= 1'b0;
                        state_r   <= START;
                    end else begin
                        // FIFO is empty here, so it cannot be full: any request is accepted.
                        tx_line_r <= 1'b1;
                        tx_idle_r <= ~UART_Tx_RQST;
                    end
                end
                START: begin
                    if (last_tick_s) begin
                        clk_cnt_r <= '0;
                        bit_idx_r <= 4'd0;
                        tx_line_r <= shift_r[0];
                        state_r   <= DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (last_tick_s) begin
                        clk_cnt_r <= '0;
                        if (bit_idx_r == LAST_DATA) begin
                            bit_idx_r <= 4'd0;
                            if (PAR_CFG == PAR_NONE) begin
                                tx_line_r <= 1'b1;
                                state_r   <= STOP;
                            end else begin
                                tx_line_r <= parity_r;
                                state_r   <= PARITY;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                            shift_r   <= shift_r >> 1;
                            tx_line_r <= shift_r[1];
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                PARITY: begin
                    if (last_tick_s) begin
                        clk_cnt_r <= '0;
                        bit_idx_r <= 4'd0;
                        tx_line_r <= 1'b1;
                        state_r   <= STOP;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (last_tick_s) begin
                        clk_cnt_r <= '0;
                        if (bit_idx_r == LAST_STOP) begin
                            bit_idx_r <= 4'd0;
                            if (pop_s) begin
                                shift_r   <= fifo_rdata_s;
                                parity_r  <= calc_parity(MAX_DATA_W'(fifo_rdata_s), PAR_CFG);
                                tx_line_r <= 1'b0;
                                state_r   <= START;
                            end else begin
                                tx_line_r <= 1'b1;
                                tx_idle_r <= ~UART_Tx_RQST;
                                state_r   <= IDLE;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_cnt_r <= '0;
                    bit_idx_r <= 4'd0;
                    tx_line_r <= 1'b1;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new overflow outranks a same-edge clear.
    always_ff @(posedge t_clk) begin
        if (t_rst) begin
            overflow_r <= 1'b0;
        end else if (UART_Tx_RQST && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else if (err_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign UART_Tx_READY_BUSY = ~fifo_full_s;
    assign UART_Tx_OUT        = tx_line_r;
    assign tx_idle            = tx_idle_r;
    assign overflow_err       = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param. Three instances with CLKS_PER_BIT=4, DATA_W=8, depth 4:
//   inst 0: no parity, 1 stop   inst 1: even parity, 2 stops   inst 2: odd parity, 1 stop
// Expected line waveforms come from a frame-level model (start, data LSB first, parity, stops).
module tb_uart_tx_fifo_param;

    localparam int CPB = 4;
    localparam int DW  = 8;
    localparam int PM [3] = '{0, 1, 2};
    localparam int SB [3] = '{1, 2, 1};

    logic          t_clk = 1'b0;
    logic          t_rst;
    logic          err_clr;
    logic          rqst  [3];
    logic [DW-1:0] data  [3];
    logic          ready [3];
    logic          line  [3];
    logic          idle  [3];
    logic [2:0]    level [3];
    logic          ovf   [3];

    int checks = 0;
    int errors = 0;

    logic cap_line [512];
    logic cap_idle [512];

    logic [DW-1:0] rx_word_a [$];
    logic          rx_stop_a [$];
    logic [DW-1:0] rx_word_b [$];
    logic          rx_par_b  [$];
    logic          rx_stop_b [$];

    always #5 t_clk = ~t_clk;

    uart_tx_fifo_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
        .t_clk(t_clk), .t_rst(t_rst), .UART_Tx_RQST(rqst[0]), .Tx_DATA(data[0]),
        .UART_Tx_READY_BUSY(ready[0]), .UART_Tx_OUT(line[0]), .tx_idle(idle[0]),
        .fifo_level(level[0]), .overflow_err(ovf[0]), .err_clr(err_clr));

    uart_tx_fifo_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
        .t_clk(t_clk), .t_rst(t_rst), .UART_Tx_RQST(rqst[1]), .Tx_DATA(data[1]),
        .UART_Tx_READY_BUSY(ready[1]), .UART_Tx_OUT(line[1]), .tx_idle(idle[1]),
        .fifo_level(level[1]), .overflow_err(ovf[1]), .err_clr(err_clr));

    uart_tx_fifo_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_c (
        .t_clk(t_clk), .t_rst(t_rst), .UART_Tx_RQST(rqst[2]), .Tx_DATA(data[2]),
        .UART_Tx_READY_BUSY(ready[2]), .UART_Tx_OUT(line[2]), .tx_idle(idle[2]),
        .fifo_level(level[2]), .overflow_err(ovf[2]), .err_clr(err_clr));

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    function automatic int frame_bits(input int pm, input int sb);
        return 1 + DW + ((pm != 0) ? 1 : 0) + sb;
    endfunction

    // Value of bit 'idx' of a frame carrying 'd'.
    function automatic logic exp_bit(input logic [8:0] d, input int pm, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (pm != 0 && idx == DW + 1) return (pm == 1) ? ^d : ~^d;
        return 1'b1;
    endfunction

    // Record line/idle of one instance for n cycles, starting after the next edge.
    task automatic capture(input int inst, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cap_line[i] = line[inst];
            cap_idle[i] = idle[inst];
        end
    endtask

    // Deserialiser: detect start sample, read each bit in its centre, queue the result.
    task automatic deser(input int inst);
        int nb;
        int b;
        logic [DW-1:0] w;
        logic pb;
        logic sok;
        nb = frame_bits(PM[inst], SB[inst]);
        forever begin
            tick();
            if (t_rst === 1'b0 && line[inst] === 1'b0) begin
                w = '0;
                pb = 1'b0;
                sok = 1'b1;
                for (int s = 1; s < nb * CPB; s++) begin
                    tick();
                    if (s % CPB == CPB / 2) begin
                        b = s / CPB;
                        if (b >= 1 && b <= DW) w[b-1] = line[inst];
                        else if (PM[inst] != 0 && b == DW + 1) pb = line[inst];
                        else if (b > DW) sok = sok & line[inst];
                    end
                end
                if (inst == 0) begin
                    rx_word_a.push_back(w);
                    rx_stop_a.push_back(sok);
                end else begin
                    rx_word_b.push_back(w);
                    rx_par_b.push_back(pb);
                    rx_stop_b.push_back(sok);
                end
            end
        end
    endtask

    task automatic test_reset();
        int low_cnt;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({line[i], ready[i], idle[i], level[i], ovf[i]} !== {1'b1, 1'b1, 1'b1, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_por inst%0d: line=%b ready=%b idle=%b level=%0d ovf=%b, required 1 1 1 0 0",
                         i, line[i], ready[i], idle[i], level[i], ovf[i]);
            end
        end
        t_rst = 1'b0;
        tick();
        rqst[0] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            data[0] = DW'($urandom);
            tick();
        end
        rqst[0] = 1'b0;
        checks++;
        if (ovf[0] !== 1'b1 || level[0] !== 3'd4) begin
            errors++;
            $display("FAIL pre_reset_fill: ovf=%b level=%0d, required 1 4", ovf[0], level[0]);
        end
        repeat (4) tick();
        t_rst = 1'b1;
        tick();
        checks++;
        if ({line[0], ready[0], idle[0], level[0], ovf[0]} !== {1'b1, 1'b1, 1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_frame: line=%b ready=%b idle=%b level=%0d ovf=%b, required 1 1 1 0 0",
                     line[0], ready[0], idle[0], level[0], ovf[0]);
        end
        tick();
        tick();
        t_rst = 1'b0;
        low_cnt = 0;
        repeat (60) begin
            tick();
            if (line[0] !== 1'b1 || idle[0] !== 1'b1) low_cnt++;
        end
        checks++;
        if (low_cnt != 0) begin
            errors++;
            $display("FAIL reset_aborts_frame: %0d non-idle cycles after reset, required 0", low_cnt);
        end
    endtask

    task automatic test_single();
        logic [0:9] spec_wave;
        spec_wave = 10'b0101001011;
        rqst[0] = 1'b1;
        data[0] = 8'hA5;
        tick();
        rqst[0] = 1'b0;
        checks++;
        if (level[0] !== 3'd1 || line[0] !== 1'b1 || idle[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: level=%0d line=%b idle=%b, required 1 1 0", level[0], line[0], idle[0]);
        end
        capture(0, 40);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (cap_line[i] !== spec_wave[i / CPB]) begin
                errors++;
                $display("FAIL single_frame cycle %0d: line=%b required %b", i, cap_line[i], spec_wave[i / CPB]);
            end
        end
        capture(0, 1);
        checks++;
        if (cap_line[0] !== 1'b1 || cap_idle[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_end: line=%b idle=%b, required 1 1", cap_line[0], cap_idle[0]);
        end
    endtask

    task automatic test_parity();
        int nb;
        int hi;
        for (int inst = 1; inst < 3; inst++) begin
            nb = frame_bits(PM[inst], SB[inst]);
            rqst[inst] = 1'b1;
            data[inst] = 8'h07;
            tick();
            rqst[inst] = 1'b0;
            capture(inst, nb * CPB + 1);
            for (int i = 0; i < nb * CPB; i++) begin
                checks++;
                if (cap_line[i] !== exp_bit(9'h007, PM[inst], i / CPB)) begin
                    errors++;
                    $display("FAIL parity_frame inst%0d cycle %0d: line=%b required %b",
                             inst, i, cap_line[i], exp_bit(9'h007, PM[inst], i / CPB));
                end
            end
            checks++;
            if (cap_line[(DW + 1) * CPB + 1] !== ((inst == 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL parity_bit inst%0d: got %b required %b", inst,
                         cap_line[(DW + 1) * CPB + 1], (inst == 1) ? 1'b1 : 1'b0);
            end
            hi = 0;
            for (int i = (DW + 2) * CPB; i < nb * CPB; i++) hi += (cap_line[i] === 1'b1) ? 1 : 0;
            checks++;
            if (hi != SB[inst] * CPB || cap_idle[nb * CPB] !== 1'b1) begin
                errors++;
                $display("FAIL stop_length inst%0d: %0d high stop cycles idle=%b, required %0d 1",
                         inst, hi, cap_idle[nb * CPB], SB[inst] * CPB);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int idle_hits;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        rqst[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            data[0] = words[n];
            tick();
        end
        rqst[0] = 1'b0;
        // First frame began right after the second push edge; two cycles already elapsed.
        capture(0, 118);
        idle_hits = 0;
        for (int i = 0; i < 118; i++) begin
            checks++;
            if (cap_line[i] !== exp_bit({1'b0, words[(i + 2) / 40]}, 0, ((i + 2) % 40) / CPB)) begin
                errors++;
                $display("FAIL b2b_frames cycle %0d: line=%b required %b", i + 2, cap_line[i],
                         exp_bit({1'b0, words[(i + 2) / 40]}, 0, ((i + 2) % 40) / CPB));
            end
            if (cap_idle[i] !== 1'b0) idle_hits++;
        end
        checks++;
        if (idle_hits != 0) begin
            errors++;
            $display("FAIL b2b_idle_early: tx_idle high %0d cycles during frames, required 0", idle_hits);
        end
        capture(0, 1);
        checks++;
        if (cap_idle[0] !== 1'b1 || cap_line[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_end: idle=%b line=%b, required 1 1", cap_idle[0], cap_line[0]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] sent [6];
        int waited;
        rx_word_a.delete();
        rx_stop_a.delete();
        rqst[0] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            sent[n] = 8'($urandom);
            data[0] = sent[n];
            tick();
        end
        rqst[0] = 1'b0;
        checks++;
        if (level[0] !== 3'd4 || ready[0] !== 1'b0 || ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: level=%0d ready=%b ovf=%b, required 4 0 1", level[0], ready[0], ovf[0]);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b required 0", ovf[0]);
        end
        err_clr = 1'b1;
        rqst[0] = 1'b1;
        data[0] = 8'hEE;
        tick();
        err_clr = 1'b0;
        rqst[0] = 1'b0;
        checks++;
        if (ovf[0] !== 1'b1 || level[0] !== 3'd4) begin
            errors++;
            $display("FAIL overflow_set_wins: ovf=%b level=%0d, required 1 4", ovf[0], level[0]);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        waited = 0;
        while ((rx_word_a.size() < 5 || idle[0] !== 1'b1) && waited < 400) begin
            tick();
            waited++;
        end
        checks++;
        if (waited >= 400 || rx_word_a.size() != 5) begin
            errors++;
            $display("FAIL overflow_drain: %0d words after %0d cycles, required 5", rx_word_a.size(), waited);
        end
        for (int i = 0; i < 5 && i < rx_word_a.size(); i++) begin
            checks++;
            if (rx_word_a[i] !== sent[i] || rx_stop_a[i] !== 1'b1) begin
                errors++;
                $display("FAIL overflow_word %0d: got %h stop=%b, required %h 1", i, rx_word_a[i], rx_stop_a[i], sent[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q [$];
        int dropped;
        int waited;
        int gap;
        dropped = 0;
        rx_word_b.delete();
        rx_par_b.delete();
        rx_stop_b.delete();
        for (int n = 0; n < 1000; n++) begin
            gap = $urandom_range(0, 60);
            repeat (gap) tick();
            data[1] = DW'($urandom);
            rqst[1] = 1'b1;
            if (ready[1] === 1'b1) exp_q.push_back(data[1]);
            else dropped++;
            tick();
            rqst[1] = 1'b0;
        end
        waited = 0;
        while ((rx_word_b.size() < exp_q.size() || idle[1] !== 1'b1) && waited < 1000) begin
            tick();
            waited++;
        end
        checks++;
        if (waited >= 1000 || rx_word_b.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: received %0d words after %0d cycles, required %0d",
                     rx_word_b.size(), waited, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_word_b.size(); i++) begin
            checks++;
            if (rx_word_b[i] !== exp_q[i] || rx_par_b[i] !== ^exp_q[i] || rx_stop_b[i] !== 1'b1) begin
                errors++;
                $display("FAIL random_word %0d: got %h par=%b stop=%b, required %h %b 1",
                         i, rx_word_b[i], rx_par_b[i], rx_stop_b[i], exp_q[i], ^exp_q[i]);
            end
        end
        checks++;
        if (ovf[1] !== ((dropped > 0) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL random_overflow: ovf=%b with %0d drops, required %b", ovf[1], dropped, (dropped > 0));
        end
    endtask

    initial begin
        fork
            deser(0);
            deser(1);
        join_none
    end

    initial begin
        t_rst = 1'b1;
        err_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rqst[i] = 1'b0;
            data[i] = '0;
        end
        repeat (3) @(posedge t_clk);
        #1;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
